vx_fpu_arb_credit: RTL and testbench
====================================

Name: vx_fpu_arb_credit

Overview:
- Connects NUM_INPUTS FPU request/response ports (per-warp or per-issue-slice) to NUM_OUTPUTS shared FPU cores.
- Adds per-input outstanding-request credit limiting and round-robin arbitration per output.
- Adds a registered (skid-buffered) request path with tag-based return routing.
- Sits between the FPU dispatch stage and the FPU core array, inside the FPU unit.

Parameters:
- NUM_INPUTS, 4, number of requester ports (>=1).
- NUM_OUTPUTS, 1, number of FPU cores (1..NUM_INPUTS).
- REQ_DATAW, 64, request payload width excluding tag (op_type, fmt, frm, operands).
- RSP_DATAW, 40, response payload width excluding tag (result, fflags, has_fflags).
- TAG_WIDTH, 8, requester tag width.
- MAX_PENDING, 4, max outstanding requests per input (>=1).
- Derived: GROUPS = ceil(NUM_INPUTS/NUM_OUTPUTS).
- Derived: SEL_BITS = max(1, clog2(GROUPS)).
- Derived: TAG_OUT_WIDTH = TAG_WIDTH + SEL_BITS.
- Derived: CNT_W = clog2(MAX_PENDING+1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid_in  in  NUM_INPUTS  request valid per input.
- req_data_in  in  NUM_INPUTS*REQ_DATAW  request payload.
- req_tag_in  in  NUM_INPUTS*TAG_WIDTH  request tag.
- req_ready_in  out  NUM_INPUTS  request accepted.
- req_valid_out  out  NUM_OUTPUTS  request valid to core.
- req_data_out  out  NUM_OUTPUTS*REQ_DATAW  payload to core.
- req_tag_out  out  NUM_OUTPUTS*TAG_OUT_WIDTH  tag to core; {orig_tag, sel} with sel in the LSBs.
- req_ready_out  in  NUM_OUTPUTS  core accepts.
- rsp_valid_in  in  NUM_OUTPUTS  core response valid.
- rsp_data_in  in  NUM_OUTPUTS*RSP_DATAW  core response payload.
- rsp_tag_in  in  NUM_OUTPUTS*TAG_OUT_WIDTH  returned extended tag.
- rsp_ready_in  out  NUM_OUTPUTS  response accepted.
- rsp_valid_out  out  NUM_INPUTS  response to requester.
- rsp_data_out  out  NUM_INPUTS*RSP_DATAW  response payload.
- rsp_tag_out  out  NUM_INPUTS*TAG_WIDTH  original tag (sel stripped).
- rsp_ready_out  in  NUM_INPUTS  requester accepts.
- pending_out  out  NUM_INPUTS*CNT_W  outstanding count per input.
- idle  out  1  all counters zero and all request buffers empty.
- rsp_err  out  1  sticky: response arrived for an input with zero credit used.

Behaviour:
- Mapping: input i -> output o = i % NUM_OUTPUTS, group g = i / NUM_OUTPUTS. sel = g.
- Response on output o with tag sel g routes to input g*NUM_OUTPUTS+o.
  - If that index >= NUM_INPUTS: response is consumed (rsp_ready_in=1), dropped, and rsp_err is set.
- Eligibility: input i is eligible when req_valid_in[i] && pending[i] != MAX_PENDING.
- Arbitration: per output, round-robin among eligible inputs in its group.
  - Pointer starts at group 0 after reset.
  - On grant, pointer advances to granted+1 (mod group size).
  - Pointer holds when there is no grant.
  - req_ready_in[i] = granted[i] && buffer for o can accept.
- Request buffer: per output, 2-entry skid buffer.
  - Outputs are driven from registers only; latency from input fire to req_valid_out is 1 cycle.
  - Sustains 1 req/cycle when req_ready_out stays high.
  - Accept while not full; a full buffer with a simultaneous pop accepts.
  - Payload and tag are held stable while valid && !ready.
- Credit counters:
  - Increment on req fire for that input.
  - Decrement on rsp_valid_out && rsp_ready_out for that input.
  - Simultaneous increment and decrement: counter unchanged.
  - A decrement at zero is illegal: the counter stays 0 and rsp_err is set.
- Response path: combinational passthrough, 0-cycle latency.
  - rsp_valid_out[dest] = rsp_valid_in[o]; rsp_ready_in[o] = rsp_ready_out[dest].
  - No contention is possible: each input is fed by exactly one output.
  - Tag has its SEL_BITS LSBs removed.
- NUM_INPUTS == NUM_OUTPUTS: GROUPS=1 and sel is constant 0 (1 bit). Behaviour is otherwise identical, with a 1:1 pass through buffers.
- Reset:
  - Buffers empty; req_valid_out=0.
  - All pending=0; RR pointers=0; rsp_err=0; idle=1.
  - req_ready_in reflects eligibility combinationally after reset deasserts.
  - rsp outputs follow their inputs combinationally.
  - Reset mid-operation discards buffered requests and counters. In-flight core responses after reset flag rsp_err and are forwarded; requesters must be reset together.

Test Plan:
- NUM_INPUTS=4, NUM_OUTPUTS=1, all valid continuously, ready_out=1, responses returned immediately -> grants 0,1,2,3,0,... each input every 4th cycle; req_tag_out = {tag, 2'bgg}; first req_valid_out 1 cycle after first fire.
- Input 0 alone valid, core never responds, MAX_PENDING=4 -> exactly 4 fires; pending_out[0]=4; req_ready_in[0]=0 thereafter. One response with tag sel 0 -> pending 3, next request accepted.
- Same cycle: request fire and response for input 2 with pending=2 -> pending stays 2.
- req_ready_out held low 5 cycles with two requests buffered -> buffer full, req_ready_in=0, req_data_out stable. Release -> both drain on consecutive cycles.
- NUM_INPUTS=3, NUM_OUTPUTS=2: response on output 1 with sel 1 (index 3) -> rsp_ready_in[1]=1, no rsp_valid_out asserted, rsp_err=1 until reset.
- Reset asserted while 2 requests are buffered and pending=[2,1,0,0] -> next cycle req_valid_out=0, all pending 0, idle=1, rsp_err=0.

Source files
------------

// File: rtl/vx_fpu_arb_credit.sv
// FPU request arbiter: NUM_INPUTS requesters share NUM_OUTPUTS cores through per-input credit
// limits, per-output round-robin, 2-entry registered request buffers and tag-routed responses.
module vx_fpu_arb_credit #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 1,
  parameter int REQ_DATAW   = 64,
  parameter int RSP_DATAW   = 40,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 4,
  localparam int GROUPS        = (NUM_INPUTS + NUM_OUTPUTS - 1) / NUM_OUTPUTS,
  localparam int SEL_BITS      = (GROUPS > 1) ? $clog2(GROUPS) : 1,
  localparam int TAG_OUT_WIDTH = TAG_WIDTH + SEL_BITS,
  localparam int CNT_W         = $clog2(MAX_PENDING + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_INPUTS-1:0]                req_valid_in,
  input  logic [NUM_INPUTS*REQ_DATAW-1:0]      req_data_in,
  input  logic [NUM_INPUTS*TAG_WIDTH-1:0]      req_tag_in,
  output logic [NUM_INPUTS-1:0]                req_ready_in,
  output logic [NUM_OUTPUTS-1:0]               req_valid_out,
  output logic [NUM_OUTPUTS*REQ_DATAW-1:0]     req_data_out,
  output logic [NUM_OUTPUTS*TAG_OUT_WIDTH-1:0] req_tag_out,
  input  logic [NUM_OUTPUTS-1:0]               req_ready_out,
  input  logic [NUM_OUTPUTS-1:0]               rsp_valid_in,
  input  logic [NUM_OUTPUTS*RSP_DATAW-1:0]     rsp_data_in,
  input  logic [NUM_OUTPUTS*TAG_OUT_WIDTH-1:0] rsp_tag_in,
  output logic [NUM_OUTPUTS-1:0]               rsp_ready_in,
  output logic [NUM_INPUTS-1:0]                rsp_valid_out,
  output logic [NUM_INPUTS*RSP_DATAW-1:0]      rsp_data_out,
  output logic [NUM_INPUTS*TAG_WIDTH-1:0]      rsp_tag_out,
  input  logic [NUM_INPUTS-1:0]                rsp_ready_out,
  output logic [NUM_INPUTS*CNT_W-1:0]          pending_out,
  output logic                                 idle,
  output logic                                 rsp_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

  logic [CNT_W-1:0]       pending_q [NUM_INPUTS];
  logic [CNT_W-1:0]       pending_d [NUM_INPUTS];
  logic                   rsp_err_q, rsp_err_d;
  logic [NUM_INPUTS-1:0]  eligible, req_fire, rsp_fire;
  logic [NUM_OUTPUTS-1:0] push, buf_empty, rsp_hit;
  logic [SEL_BITS-1:0]    win_sel [NUM_OUTPUTS];

  // NOTE: every always_comb output gets a default before any conditional write, so no latches.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      eligible[i] = req_valid_in[i] && (pending_q[i] != CNT_MAX);
  end

  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
    localparam int GS = (NUM_INPUTS - o + NUM_OUTPUTS - 1) / NUM_OUTPUTS;
    localparam logic [SEL_BITS-1:0] LAST = SEL_BITS'(GS - 1);

    logic [SEL_BITS-1:0]      rr_q, rr_d, win;
    logic                     found, can_accept, pop;
    logic [1:0]               cnt_q, cnt_d;
    logic [REQ_DATAW-1:0]     in_data, data0_q, data1_q;
    logic [TAG_OUT_WIDTH-1:0] in_tag, tag0_q, tag1_q;

    // Search starts at the pointer and wraps within this output's group.
    always_comb begin
      int g;
      found = 1'b0;
      win   = '0;
      g     = 0;
      for (int k = 0; k < GS; k++) begin
        g = int'(rr_q) + k;
        if (g >= GS) g = g - GS;
        if (!found && eligible[g*NUM_OUTPUTS + o]) begin
          found = 1'b1;
          win   = SEL_BITS'(g);
        end
      end
    end

    always_comb begin
      in_data = '0;
      in_tag  = '0;
      for (int g = 0; g < GS; g++) begin
        if (win == SEL_BITS'(g)) begin
          in_data = req_data_in[(g*NUM_OUTPUTS + o)*REQ_DATAW +: REQ_DATAW];
          in_tag  = {req_tag_in[(g*NUM_OUTPUTS + o)*TAG_WIDTH +: TAG_WIDTH], SEL_BITS'(g)};
        end
      end
    end

    assign pop          = (cnt_q != 2'd0) && req_ready_out[o];
    assign can_accept   = (cnt_q != 2'd2) || pop;
    assign push[o]      = found && can_accept;
    assign win_sel[o]   = win;
    assign buf_empty[o] = (cnt_q == 2'd0);
    assign rr_d         = (win == LAST) ? '0 : win + 1'b1;
    assign cnt_d        = cnt_q + {1'b0, push[o]} - {1'b0, pop};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        rr_q  <= '0;
      end else begin
        cnt_q <= cnt_d;
        if (push[o]) rr_q <= rr_d;
      end
    end

    // NOTE: payload slots are not reset; cnt_q alone says which slots hold live data.
    always_ff @(posedge clk) begin
      if (push[o] && ((cnt_q == 2'd0) || (cnt_q == 2'd1 && pop))) begin
        data0_q <= in_data;
        tag0_q  <= in_tag;
      end else if (pop && cnt_q == 2'd2) begin
        data0_q <= data1_q;
        tag0_q  <= tag1_q;
      end
      if (push[o] && ((cnt_q == 2'd1 && !pop) || cnt_q == 2'd2)) begin
        data1_q <= in_data;
        tag1_q  <= in_tag;
      end
    end

    assign req_valid_out[o]                              = !buf_empty[o];
    assign req_data_out[o*REQ_DATAW +: REQ_DATAW]         = data0_q;
    assign req_tag_out[o*TAG_OUT_WIDTH +: TAG_OUT_WIDTH]  = tag0_q;
  end

  always_comb begin
    req_fire = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      req_fire[i] = push[i % NUM_OUTPUTS] &&
                    (win_sel[i % NUM_OUTPUTS] == SEL_BITS'(i / NUM_OUTPUTS));
  end

  assign req_ready_in = req_fire;

  // Each input listens to exactly one output; the tag's sel field decides who sees valid.
  always_comb begin
    rsp_valid_out = '0;
    rsp_data_out  = '0;
    rsp_tag_out   = '0;
    rsp_ready_in  = '1;
    rsp_hit       = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      rsp_data_out[i*RSP_DATAW +: RSP_DATAW] =
        rsp_data_in[(i % NUM_OUTPUTS)*RSP_DATAW +: RSP_DATAW];
      rsp_tag_out[i*TAG_WIDTH +: TAG_WIDTH] =
        rsp_tag_in[(i % NUM_OUTPUTS)*TAG_OUT_WIDTH + SEL_BITS +: TAG_WIDTH];
      if (rsp_tag_in[(i % NUM_OUTPUTS)*TAG_OUT_WIDTH +: SEL_BITS] == SEL_BITS'(i / NUM_OUTPUTS)) begin
        rsp_valid_out[i]              = rsp_valid_in[i % NUM_OUTPUTS];
        rsp_ready_in[i % NUM_OUTPUTS] = rsp_ready_out[i];
        rsp_hit[i % NUM_OUTPUTS]      = 1'b1;
      end
    end
  end

  assign rsp_fire = rsp_valid_out & rsp_ready_out;

  always_comb begin
    pending_d = pending_q;
    rsp_err_d = rsp_err_q;
    for (int o = 0; o < NUM_OUTPUTS; o++)
      if (rsp_valid_in[o] && !rsp_hit[o]) rsp_err_d = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (rsp_fire[i] && pending_q[i] == '0) rsp_err_d = 1'b1;
      if (req_fire[i] && !rsp_fire[i])
        pending_d[i] = pending_q[i] + 1'b1;
      else if (!req_fire[i] && rsp_fire[i] && pending_q[i] != '0)
        pending_d[i] = pending_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) pending_q[i] <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  always_comb begin
    pending_out = '0;
    idle        = &buf_empty;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      pending_out[i*CNT_W +: CNT_W] = pending_q[i];
      if (pending_q[i] != '0) idle = 1'b0;
    end
  end

  assign rsp_err = rsp_err_q;

endmodule

// File: tb/tb_vx_fpu_arb_credit.sv
// Directed bench: 4->1 instance for arbitration/credits/buffering, 3->2 instance for routing.
module tb_vx_fpu_arb_credit;
  localparam int TOW = 10;
  localparam int TOW2 = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 4 inputs, 1 output
  logic [3:0]     req_valid_in, req_ready_in, rsp_valid_out, rsp_ready_out;
  logic [255:0]   req_data_in;
  logic [31:0]    req_tag_in, rsp_tag_out;
  logic [0:0]     req_valid_out, req_ready_out, rsp_valid_in, rsp_ready_in;
  logic [63:0]    req_data_out;
  logic [TOW-1:0] req_tag_out, rsp_tag_in;
  logic [39:0]    rsp_data_in;
  logic [159:0]   rsp_data_out;
  logic [11:0]    pending_out;
  logic           idle, rsp_err;

  // 3 inputs, 2 outputs
  logic [2:0]       req_valid_in2, req_ready_in2, rsp_valid_out2, rsp_ready_out2;
  logic [191:0]     req_data_in2;
  logic [23:0]      req_tag_in2, rsp_tag_out2;
  logic [1:0]       req_valid_out2, req_ready_out2, rsp_valid_in2, rsp_ready_in2;
  logic [127:0]     req_data_out2;
  logic [2*TOW2-1:0] req_tag_out2, rsp_tag_in2;
  logic [79:0]      rsp_data_in2;
  logic [119:0]     rsp_data_out2;
  logic [8:0]       pending_out2;
  logic             idle2, rsp_err2;

  int n_checks = 0;
  int n_fail = 0;

  vx_fpu_arb_credit dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready_in(req_ready_in), .req_valid_out(req_valid_out), .req_data_out(req_data_out),
    .req_tag_out(req_tag_out), .req_ready_out(req_ready_out), .rsp_valid_in(rsp_valid_in),
    .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in), .rsp_ready_in(rsp_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out),
    .rsp_ready_out(rsp_ready_out), .pending_out(pending_out), .idle(idle), .rsp_err(rsp_err)
  );

  vx_fpu_arb_credit #(.NUM_INPUTS(3), .NUM_OUTPUTS(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in2), .req_data_in(req_data_in2), .req_tag_in(req_tag_in2),
    .req_ready_in(req_ready_in2), .req_valid_out(req_valid_out2), .req_data_out(req_data_out2),
    .req_tag_out(req_tag_out2), .req_ready_out(req_ready_out2), .rsp_valid_in(rsp_valid_in2),
    .rsp_data_in(rsp_data_in2), .rsp_tag_in(rsp_tag_in2), .rsp_ready_in(rsp_ready_in2),
    .rsp_valid_out(rsp_valid_out2), .rsp_data_out(rsp_data_out2), .rsp_tag_out(rsp_tag_out2),
    .rsp_ready_out(rsp_ready_out2), .pending_out(pending_out2), .idle(idle2), .rsp_err(rsp_err2)
  );

  // Payload of input i: data 64'hDA7A_0000_0000_000i, tag 8'hA0+i (second instance: B0B0../C0+i).
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    req_valid_in = '0; req_ready_out = '0; rsp_valid_in = '0; rsp_tag_in = '0;
    rsp_data_in = '0; rsp_ready_out = '0;
    req_valid_in2 = '0; req_ready_out2 = '0; rsp_valid_in2 = '0; rsp_tag_in2 = '0;
    rsp_data_in2 = '0; rsp_ready_out2 = '0;
    for (int i = 0; i < 4; i++) begin
      req_data_in[i*64 +: 64] = 64'hDA7A_0000_0000_0000 + 64'(i);
      req_tag_in[i*8 +: 8]    = 8'hA0 + 8'(i);
    end
    for (int i = 0; i < 3; i++) begin
      req_data_in2[i*64 +: 64] = 64'hB0B0_0000_0000_0000 + 64'(i);
      req_tag_in2[i*8 +: 8]    = 8'hC0 + 8'(i);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    n_checks++; if (req_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b expected 0", req_valid_out); end
    n_checks++; if (pending_out !== 12'h000) begin n_fail++; $display("FAIL reset_pending: got %h expected 000", pending_out); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    n_checks++; if (req_ready_in !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_in: got %b expected 0000", req_ready_in); end
    // Combinational response passthrough to input 1
    rsp_valid_in = 1'b1; rsp_tag_in = {8'h9A, 2'b01}; rsp_data_in = 40'h12_3456_789A; rsp_ready_out = 4'b0010;
    #1;
    n_checks++; if (rsp_valid_out !== 4'b0010) begin n_fail++; $display("FAIL pass_valid: got %b expected 0010", rsp_valid_out); end
    n_checks++; if (rsp_ready_in !== 1'b1) begin n_fail++; $display("FAIL pass_ready: got %b expected 1", rsp_ready_in); end
    n_checks++; if (rsp_tag_out[15:8] !== 8'h9A) begin n_fail++; $display("FAIL pass_tag: got %h expected 9a", rsp_tag_out[15:8]); end
    n_checks++; if (rsp_data_out[79:40] !== 40'h12_3456_789A) begin n_fail++; $display("FAIL pass_data: got %h expected 123456789a", rsp_data_out[79:40]); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy;
    logic [9:0] exp_tag;
    logic [63:0] exp_data;
    int prev;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_valid_in = 4'hF; req_ready_out = 1'b1;
      rsp_valid_in = req_valid_out; rsp_tag_in = req_tag_out; rsp_ready_out = 4'hF;
      #1;
      exp_rdy = 4'b0001 << (k % 4);
      n_checks++; if (req_ready_in !== exp_rdy) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready_in, exp_rdy); end
      if (k == 0) begin
        n_checks++; if (req_valid_out !== 1'b0) begin n_fail++; $display("FAIL rr_first_latency: got %b expected 0", req_valid_out); end
      end else begin
        prev = (k - 1) % 4;
        exp_tag  = {8'hA0 + 8'(prev), 2'(prev)};
        exp_data = 64'hDA7A_0000_0000_0000 + 64'(prev);
        n_checks++; if (req_valid_out !== 1'b1) begin n_fail++; $display("FAIL rr_valid_out[%0d]: got %b expected 1", k, req_valid_out); end
        n_checks++; if (req_tag_out !== exp_tag) begin n_fail++; $display("FAIL rr_tag_out[%0d]: got %h expected %h", k, req_tag_out, exp_tag); end
        n_checks++; if (req_data_out !== exp_data) begin n_fail++; $display("FAIL rr_data_out[%0d]: got %h expected %h", k, req_data_out, exp_data); end
        n_checks++; if (rsp_valid_out !== (4'b0001 << prev)) begin n_fail++; $display("FAIL rr_rsp_route[%0d]: got %b expected %b", k, rsp_valid_out, 4'b0001 << prev); end
      end
    end
    @(negedge clk);
    req_valid_in = 4'h0; rsp_valid_in = req_valid_out; rsp_tag_in = req_tag_out;
    @(negedge clk);
    rsp_valid_in = 1'b0;
    #1;
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rr_drain_idle: got %b expected 1", idle); end
    n_checks++; if (pending_out !== 12'h000) begin n_fail++; $display("FAIL rr_drain_pending: got %h expected 000", pending_out); end
  endtask

  task automatic test_credit_limit;
    logic [3:0] exp_rdy;
    int fires;
    do_reset();
    fires = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_valid_in = 4'b0001; req_ready_out = 1'b1;
      #1;
      exp_rdy = (c < 4) ? 4'b0001 : 4'b0000;
      n_checks++; if (req_ready_in !== exp_rdy) begin n_fail++; $display("FAIL credit_ready[%0d]: got %b expected %b", c, req_ready_in, exp_rdy); end
      if (req_ready_in[0] === 1'b1) fires++;
    end
    n_checks++; if (fires !== 4) begin n_fail++; $display("FAIL credit_fires: got %0d expected 4", fires); end
    n_checks++; if (pending_out[2:0] !== 3'd4) begin n_fail++; $display("FAIL credit_pending_max: got %0d expected 4", pending_out[2:0]); end
    @(negedge clk);
    rsp_valid_in = 1'b1; rsp_tag_in = {8'h55, 2'b00}; rsp_ready_out = 4'hF;
    #1;
    n_checks++; if (rsp_valid_out !== 4'b0001) begin n_fail++; $display("FAIL credit_rsp_valid: got %b expected 0001", rsp_valid_out); end
    n_checks++; if (rsp_tag_out[7:0] !== 8'h55) begin n_fail++; $display("FAIL credit_rsp_tag: got %h expected 55", rsp_tag_out[7:0]); end
    n_checks++; if (req_ready_in !== 4'b0000) begin n_fail++; $display("FAIL credit_still_full: got %b expected 0000", req_ready_in); end
    @(negedge clk);
    rsp_valid_in = 1'b0;
    #1;
    n_checks++; if (pending_out[2:0] !== 3'd3) begin n_fail++; $display("FAIL credit_after_rsp: got %0d expected 3", pending_out[2:0]); end
    n_checks++; if (req_ready_in !== 4'b0001) begin n_fail++; $display("FAIL credit_reaccept: got %b expected 0001", req_ready_in); end
    @(negedge clk);
    req_valid_in = 4'b0000;
    #1;
    n_checks++; if (pending_out[2:0] !== 3'd4) begin n_fail++; $display("FAIL credit_refill: got %0d expected 4", pending_out[2:0]); end
  endtask

  task automatic test_simul_inc_dec;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      req_valid_in = 4'b0100; req_ready_out = 1'b1;
      #1;
      n_checks++; if (req_ready_in !== 4'b0100) begin n_fail++; $display("FAIL simul_fill[%0d]: got %b expected 0100", c, req_ready_in); end
    end
    @(negedge clk);
    rsp_valid_in = 1'b1; rsp_tag_in = {8'h77, 2'b10}; rsp_ready_out = 4'hF;
    #1;
    n_checks++; if (pending_out[8:6] !== 3'd2) begin n_fail++; $display("FAIL simul_pending_before: got %0d expected 2", pending_out[8:6]); end
    n_checks++; if (req_ready_in !== 4'b0100) begin n_fail++; $display("FAIL simul_req_fire: got %b expected 0100", req_ready_in); end
    n_checks++; if (rsp_valid_out !== 4'b0100) begin n_fail++; $display("FAIL simul_rsp_fire: got %b expected 0100", rsp_valid_out); end
    @(negedge clk);
    req_valid_in = 4'b0000; rsp_valid_in = 1'b0;
    #1;
    n_checks++; if (pending_out[8:6] !== 3'd2) begin n_fail++; $display("FAIL simul_pending_after: got %0d expected 2", pending_out[8:6]); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL simul_no_err: got %b expected 0", rsp_err); end
  endtask

  task automatic test_backpressure;
    logic [3:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      req_valid_in = 4'b0011; req_ready_out = 1'b0;
      #1;
      exp_rdy = (c == 0) ? 4'b0001 : 4'b0010;
      n_checks++; if (req_ready_in !== exp_rdy) begin n_fail++; $display("FAIL bp_fill[%0d]: got %b expected %b", c, req_ready_in, exp_rdy); end
    end
    for (int c = 2; c < 7; c++) begin
      @(negedge clk);
      #1;
      n_checks++; if (req_ready_in !== 4'b0000) begin n_fail++; $display("FAIL bp_full_ready[%0d]: got %b expected 0000", c, req_ready_in); end
      n_checks++; if (req_data_out !== 64'hDA7A_0000_0000_0000) begin n_fail++; $display("FAIL bp_data_stable[%0d]: got %h expected da7a000000000000", c, req_data_out); end
      n_checks++; if (req_valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held[%0d]: got %b expected 1", c, req_valid_out); end
    end
    @(negedge clk);
    req_valid_in = 4'b0100; req_ready_out = 1'b1;
    #1;
    n_checks++; if (req_ready_in !== 4'b0100) begin n_fail++; $display("FAIL bp_full_pop_accept: got %b expected 0100", req_ready_in); end
    @(negedge clk);
    req_valid_in = 4'b0000;
    #1;
    n_checks++; if (req_data_out !== 64'hDA7A_0000_0000_0001) begin n_fail++; $display("FAIL bp_drain1_data: got %h expected da7a000000000001", req_data_out); end
    n_checks++; if (req_tag_out !== {8'hA1, 2'b01}) begin n_fail++; $display("FAIL bp_drain1_tag: got %h expected %h", req_tag_out, {8'hA1, 2'b01}); end
    @(negedge clk);
    #1;
    n_checks++; if (req_tag_out !== {8'hA2, 2'b10}) begin n_fail++; $display("FAIL bp_drain2_tag: got %h expected %h", req_tag_out, {8'hA2, 2'b10}); end
    @(negedge clk);
    #1;
    n_checks++; if (req_valid_out !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", req_valid_out); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    @(negedge clk);
    req_valid_in = 4'b0001; req_ready_out = 1'b1;
    @(negedge clk);
    req_valid_in = 4'b0001; req_ready_out = 1'b1;
    @(negedge clk);
    req_valid_in = 4'b0010; req_ready_out = 1'b0;
    @(negedge clk);
    req_valid_in = 4'b0000;
    rsp_valid_in = 1'b1; rsp_tag_in = {8'h33, 2'b11}; rsp_ready_out = 4'hF;
    #1;
    n_checks++; if (pending_out !== 12'h00A) begin n_fail++; $display("FAIL mid_pending_before: got %h expected 00a", pending_out); end
    n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", idle); end
    @(negedge clk);
    rsp_valid_in = 1'b0;
    #1;
    n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL mid_err_zero_credit: got %b expected 1", rsp_err); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (req_valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_valid_out: got %b expected 0", req_valid_out); end
    n_checks++; if (pending_out !== 12'h000) begin n_fail++; $display("FAIL mid_pending_after: got %h expected 000", pending_out); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL mid_idle: got %b expected 1", idle); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL mid_err_cleared: got %b expected 0", rsp_err); end
  endtask

  task automatic test_out_of_range;
    do_reset();
    @(negedge clk);
    rsp_valid_in2 = 2'b10; rsp_tag_in2 = {8'h44, 1'b1, 9'h000}; rsp_ready_out2 = 3'b000;
    #1;
    n_checks++; if (rsp_ready_in2 !== 2'b10) begin n_fail++; $display("FAIL oor_ready_in: got %b expected 10", rsp_ready_in2); end
    n_checks++; if (rsp_valid_out2 !== 3'b000) begin n_fail++; $display("FAIL oor_no_valid: got %b expected 000", rsp_valid_out2); end
    @(negedge clk);
    rsp_valid_in2 = 2'b00;
    #1;
    n_checks++; if (rsp_err2 !== 1'b1) begin n_fail++; $display("FAIL oor_err_set: got %b expected 1", rsp_err2); end
    @(negedge clk);
    rsp_valid_in2 = 2'b10; rsp_tag_in2 = {8'h45, 1'b0, 9'h000}; rsp_ready_out2 = 3'b010;
    #1;
    n_checks++; if (rsp_valid_out2 !== 3'b010) begin n_fail++; $display("FAIL map_rsp_valid: got %b expected 010", rsp_valid_out2); end
    n_checks++; if (rsp_tag_out2[15:8] !== 8'h45) begin n_fail++; $display("FAIL map_rsp_tag: got %h expected 45", rsp_tag_out2[15:8]); end
    @(negedge clk);
    rsp_valid_in2 = 2'b00; rsp_ready_out2 = 3'b000;
    req_valid_in2 = 3'b100; req_ready_out2 = 2'b11;
    #1;
    n_checks++; if (req_ready_in2 !== 3'b100) begin n_fail++; $display("FAIL map_req_grant: got %b expected 100", req_ready_in2); end
    n_checks++; if (rsp_err2 !== 1'b1) begin n_fail++; $display("FAIL oor_err_sticky: got %b expected 1", rsp_err2); end
    @(negedge clk);
    req_valid_in2 = 3'b000;
    #1;
    n_checks++; if (req_valid_out2 !== 2'b01) begin n_fail++; $display("FAIL map_req_valid: got %b expected 01", req_valid_out2); end
    n_checks++; if (req_tag_out2[8:0] !== {8'hC2, 1'b1}) begin n_fail++; $display("FAIL map_req_tag: got %h expected %h", req_tag_out2[8:0], {8'hC2, 1'b1}); end
    n_checks++; if (req_data_out2[63:0] !== 64'hB0B0_0000_0000_0002) begin n_fail++; $display("FAIL map_req_data: got %h expected b0b0000000000002", req_data_out2[63:0]); end
    do_reset();
    #1;
    n_checks++; if (rsp_err2 !== 1'b0) begin n_fail++; $display("FAIL oor_err_reset: got %b expected 0", rsp_err2); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_round_robin();
    test_credit_limit();
    test_simul_inc_dec();
    test_backpressure();
    test_reset_mid();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
